// File: rtl/abc_sweep_sequencer.sv
// Stimulus sequencer for the 3-in/2-out lab block: walks {a,b,c} through 000..111,
// holding each pattern DWELL cycles and capturing {x,y} on the last cycle of each dwell.
module abc_sweep_sequencer #(
   parameter int DWELL = 10,
   parameter int CNT_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic        a,
   output logic        b,
   output logic        c,
   input  logic        x_in,
   input  logic        y_in,
   output logic        busy,
   output logic        done,
   output logic [2:0]  pattern_idx,
   output logic [15:0] result
);

   typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [15:0]      result_q, result_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   // busy/done are computed from the next state so the flops line up with the state register
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      result_d = result_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d  = DRIVE;
               cnt_d    = '0;
               idx_d    = '0;
               result_d = '0;
               busy_d   = 1'b1;
            end
         end
         DRIVE: begin
            busy_d = 1'b1;
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               idx_d   = '0;
               busy_d  = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               result_d[{idx_q, 1'b0} +: 2] = {x_in, y_in};
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign {a, b, c}   = idx_q;
   assign pattern_idx = idx_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign result      = result_q;

endmodule

// File: tb/tb_abc_sweep_sequencer.sv
// Directed bench for abc_sweep_sequencer: DWELL=10 unit driving a parity/majority stub,
// plus a DWELL=1 unit driving a constant x=1,y=0 stub.
module tb_abc_sweep_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, abort, start2;
   logic        a, b, c, x_in, y_in, busy, done;
   logic [2:0]  pattern_idx;
   logic [15:0] result;
   logic        a2, b2, c2, busy2, done2;
   logic        x2 = 1'b1;
   logic        y2 = 1'b0;
   logic        abort2 = 1'b0;
   logic [2:0]  pattern_idx2;
   logic [15:0] result2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign x_in = a ^ b ^ c;
   assign y_in = (a & b) | (b & c) | (a & c);

   abc_sweep_sequencer #(.DWELL(10), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .a(a), .b(b), .c(c), .x_in(x_in), .y_in(y_in),
      .busy(busy), .done(done), .pattern_idx(pattern_idx), .result(result)
   );

   abc_sweep_sequencer #(.DWELL(1), .CNT_W(1)) dut1 (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .a(a2), .b(b2), .c(c2), .x_in(x2), .y_in(y2),
      .busy(busy2), .done(done2), .pattern_idx(pattern_idx2), .result(result2)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Caller has already applied start and ticked once; returns cycles from start to done.
   task automatic wait_done(output int cyc, output int pulses);
      cyc = 1;
      pulses = 0;
      while (!done && cyc < 200) begin
         tick(1);
         cyc++;
         if (cyc == 15) begin
            chk("mid_idx1", {29'd0, pattern_idx}, 32'd1);
            chk("mid_abc1", {29'd0, a, b, c}, 32'd1);
         end
         if (cyc == 80) chk("last_dwell_busy_idx7", {28'd0, busy, pattern_idx}, {28'd0, 1'b1, 3'd7});
      end
      if (done) pulses = 1;
   endtask

   int cyc, pulses, guard, seen;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
      tick(2);
      chk("rst_abc", {29'd0, a, b, c}, 32'd0);
      chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
      chk("rst_idx", {29'd0, pattern_idx}, 32'd0);
      chk("rst_result", {16'd0, result}, 32'h0000);
      rst = 1'b0;
      tick(1);

      // full sweep
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("sweep_first_busy_idx", {28'd0, busy, pattern_idx}, {28'd0, 1'b1, 3'd0});
      wait_done(cyc, pulses);
      chk("sweep_latency", cyc, 81);
      chk("sweep_result", {16'd0, result}, 32'h0000D668);
      chk("sweep_busy_in_done", {31'd0, busy}, 32'd0);
      tick(1);
      chk("sweep_done_one_cycle", {30'd0, done, busy}, 32'd0);
      chk("sweep_result_hold", {16'd0, result}, 32'h0000D668);

      // abort during pattern 4: slots 0..3 captured, the rest cleared by start
      start = 1'b1;
      tick(1);
      start = 1'b0;
      guard = 0;
      while (pattern_idx != 3'd4 && guard < 100) begin
         tick(1);
         guard++;
      end
      tick(5);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("abort_busy_idx", {28'd0, busy, pattern_idx}, 32'd0);
      chk("abort_abc", {29'd0, a, b, c}, 32'd0);
      chk("abort_result", {16'd0, result}, 32'h00000068);
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         if (done || busy) seen++;
      end
      chk("abort_no_done", seen, 0);

      // abort beats start in IDLE
      start = 1'b1; abort = 1'b1;
      tick(1);
      start = 1'b0; abort = 1'b0;
      chk("abort_beats_start", {31'd0, busy}, 32'd0);
      chk("abort_beats_start_result", {16'd0, result}, 32'h00000068);

      // start held high for the whole sweep, including the DONE cycle
      start = 1'b1;
      tick(1);
      wait_done(cyc, pulses);
      chk("held_latency", cyc, 81);
      chk("held_pulses", pulses, 1);
      tick(1);
      start = 1'b0;
      chk("held_no_restart", {30'd0, busy, done}, 32'd0);
      tick(1);
      chk("held_idle", {30'd0, busy, done}, 32'd0);

      // DWELL=1 unit with constant stub
      start2 = 1'b1;
      tick(1);
      start2 = 1'b0;
      cyc = 1;
      while (!done2 && cyc < 50) begin
         tick(1);
         cyc++;
      end
      chk("d1_latency", cyc, 9);
      chk("d1_result", {16'd0, result2}, 32'h0000AAAA);
      chk("d1_idx_at_done", {29'd0, pattern_idx2}, 32'd7);

      // reset in the middle of pattern 5, then a clean re-sweep
      start = 1'b1;
      tick(1);
      start = 1'b0;
      guard = 0;
      while (pattern_idx != 3'd5 && guard < 100) begin
         tick(1);
         guard++;
      end
      tick(3);
      rst = 1'b1;
      tick(1);
      chk("midrst_abc_idx", {26'd0, a, b, c, pattern_idx}, 32'd0);
      chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
      chk("midrst_result", {16'd0, result}, 32'h0000);
      rst = 1'b0;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("resweep_start_idx0", {28'd0, busy, pattern_idx}, {28'd0, 1'b1, 3'd0});
      wait_done(cyc, pulses);
      chk("resweep_latency", cyc, 81);
      chk("resweep_result", {16'd0, result}, 32'h0000D668);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
